serial_word_feeder: RTL

Parallel-to-serial front end for the serial divisibility-by-three checker. Accepts `WIDTH`-bit words over a valid/ready handshake and emits each word MSB-first, one bit per clock. A one-cycle clear pulse precedes every word so the downstream checker restarts per word. A one-word holding buffer allows the next word to be accepted while the current one is shifting, giving a sustained rate of one word per `WIDTH+1` cycles.

---
 rtl/serial_word_feeder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_word_feeder.sv
// serial_word_feeder
//   Parallel-to-serial front end for a serial divisibility-by-three checker.
//   Words arrive over a valid/ready handshake. Each word is sent MSB first,
//   one bit per clock. A one-cycle clear pulse comes before every word so the
//   checker restarts. A one-word holding buffer takes the next word while the
//   current one is shifting, so the sustained rate is one word per WIDTH+1
//   cycles.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   din        in   parallel word, sampled on accept
//   din_valid  in   upstream word present
//   din_ready  out  holding buffer can take a word this cycle
//   clr_out    out  one-cycle pulse before the first bit of each word
//   ser_bit    out  serial data bit, MSB first (0 when ser_valid is low)
//   ser_valid  out  ser_bit carries a data bit this cycle
//   ser_last   out  high with the final (LSB) bit of a word
//
// States
//   IDLE  | nothing to send, outputs low; leave when the holding buffer fills
//   CLEAR | clr_out pulse; hold -> sh on the edge that leaves this state
//   SHIFT | one data bit per cycle from sh[WIDTH-1]; ser_last on the final bit

module serial_word_feeder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             clr_out,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic accept;
  logic transfer;
  logic last_bit;

  // The buffer drains into sh on the edge that leaves CLEAR. It can therefore
  // take a new word on that same edge. This lets a held valid stream sustain
  // one word per WIDTH+1 cycles. Only registered state is decoded here.
  assign din_ready = ~hold_full_q | (state_q == S_CLEAR);
  assign accept    = din_valid & din_ready;
  assign transfer  = (state_q == S_CLEAR);
  assign last_bit  = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hold_full_q) state_d = S_CLEAR;
      S_CLEAR: state_d = S_SHIFT;
      S_SHIFT: begin
        // A word accepted on this same edge also counts, so there is no gap.
        if (last_bit) state_d = (hold_full_q | accept) ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;

    // When an accept and a transfer happen on the same edge, the new word
    // refills the buffer. In that case hold_full stays set.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else if (transfer) begin
      hold_full_d = 1'b0;
    end

    if (transfer) begin
      sh_d  = hold_q;
      cnt_d = '0;
    end else if (state_q == S_SHIFT) begin
      sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    clr_out   = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    ser_last  = 1'b0;
    unique case (state_q)
      S_CLEAR: clr_out = 1'b1;
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = sh_q[WIDTH-1];
        ser_last  = last_bit;
      end
      default: ;
    endcase
  end

endmodule
